// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter interface.
//
// Purpose: bundles the functional-unit result inputs and the CDB broadcast
// outputs of cdb_arbiter into one port.
//
// Signals:
//   fu_finish  [N_FU]         1-cycle result-valid pulse per FU
//   fu_data    [N_FU*DATA_W]  FU results, FU i at [i*DATA_W +: DATA_W]
//   fu_tag     [N_FU*TAG_W]   destination RS tags, same packing
//   fu_pc      [N_FU*PC_W]    instruction PCs, same packing
//   fu_busy    [N_FU]         holding buffer i has an unbroadcast result
//   cdb_valid                 broadcast valid this cycle
//   cdb_rs_num [TAG_W]        broadcast RS tag (0 when idle)
//   cdb_data   [DATA_W]       broadcast value (0 when idle)
//   cdb_pc     [PC_W]         broadcast PC (0 when idle)
//   cdb_grant  [N_FU]         one-hot source of the current broadcast
//   ovf_err                   sticky: a result was dropped
//
// Modports: master = core / FU side, slave = arbiter side.

interface cdb_arbiter_if #(
    parameter int N_FU   = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int PC_W   = 32
);
    logic [N_FU-1:0]        fu_finish;
    logic [N_FU*DATA_W-1:0] fu_data;
    logic [N_FU*TAG_W-1:0]  fu_tag;
    logic [N_FU*PC_W-1:0]   fu_pc;
    logic [N_FU-1:0]        fu_busy;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_rs_num;
    logic [DATA_W-1:0]      cdb_data;
    logic [PC_W-1:0]        cdb_pc;
    logic [N_FU-1:0]        cdb_grant;
    logic                   ovf_err;

    modport master (
        output fu_finish, fu_data, fu_tag, fu_pc,
        input  fu_busy, cdb_valid, cdb_rs_num, cdb_data, cdb_pc, cdb_grant, ovf_err
    );

    modport slave (
        input  fu_finish, fu_data, fu_tag, fu_pc,
        output fu_busy, cdb_valid, cdb_rs_num, cdb_data, cdb_pc, cdb_grant, ovf_err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter for the Tomasulo core.
//
// Purpose: captures each functional unit's result / RS tag / PC into a
// per-FU holding buffer, picks one buffered result per cycle and broadcasts
// it (registered) on the CDB. fu_busy tells the core which FUs still hold an
// unbroadcast result.
//
// Ports:
//   clk   core clock, all state on the rising edge
//   rst   asynchronous active-low reset (0 = reset)
//   bus   cdb_arbiter_if.slave (FU inputs, CDB outputs, fu_busy, ovf_err)
//
// Build option:
//   CDB_RR_EN  defined   -> round-robin arbitration starting at a rotating
//                           pointer, pointer moves past each winner
//              undefined -> fixed priority, lowest FU index wins
//
// Latency: finish sampled at edge k -> broadcast visible after edge k+1.

module cdb_arbiter #(
    parameter int N_FU   = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int PC_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]   pending_q, pending_d;
    logic [DATA_W-1:0] data_q [N_FU];
    logic [DATA_W-1:0] data_d [N_FU];
    logic [TAG_W-1:0]  tag_q  [N_FU];
    logic [TAG_W-1:0]  tag_d  [N_FU];
    logic [PC_W-1:0]   pc_q   [N_FU];
    logic [PC_W-1:0]   pc_d   [N_FU];
    logic              ovf_q, ovf_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [N_FU-1:0]   cdb_grant_q, cdb_grant_d;
    logic [TAG_W-1:0]  cdb_rs_num_q, cdb_rs_num_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [PC_W-1:0]   cdb_pc_q, cdb_pc_d;

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [N_FU-1:0]   grant;

`ifdef CDB_RR_EN
    localparam logic [IDX_W:0]   N_FU_W = (IDX_W+1)'(N_FU);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FU - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan pending[] starting at ptr, wrapping past the last FU.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_FU; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= N_FU_W) begin
                sum = sum - N_FU_W;
            end
            cand = sum[IDX_W-1:0];
            if (!win_valid && pending_q[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_valid) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest pending index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_FU; k++) begin
            if (!win_valid && pending_q[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_FU; i++) begin
            grant[i] = win_valid && (win_idx == IDX_W'(i));
        end
    end

    // Buffer update. A buffer being granted this edge frees up in time to
    // accept a new result on the same edge, so pending stays set.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < N_FU; i++) begin
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
            pc_d[i]   = pc_q[i];
            if (grant[i]) begin
                pending_d[i] = 1'b0;
            end
            if (bus.fu_finish[i]) begin
                if (!pending_q[i] || grant[i]) begin
                    pending_d[i] = 1'b1;
                    data_d[i]    = bus.fu_data[i*DATA_W +: DATA_W];
                    tag_d[i]     = bus.fu_tag[i*TAG_W +: TAG_W];
                    pc_d[i]      = bus.fu_pc[i*PC_W +: PC_W];
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cdb_valid_d  = win_valid;
        cdb_grant_d  = grant;
        cdb_rs_num_d = '0;
        cdb_data_d   = '0;
        cdb_pc_d     = '0;
        if (win_valid) begin
            cdb_rs_num_d = tag_q[win_idx];
            cdb_data_d   = data_q[win_idx];
            cdb_pc_d     = pc_q[win_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= '0;
            ovf_q        <= 1'b0;
            cdb_valid_q  <= 1'b0;
            cdb_grant_q  <= '0;
            cdb_rs_num_q <= '0;
            cdb_data_q   <= '0;
            cdb_pc_q     <= '0;
            for (int i = 0; i < N_FU; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_grant_q  <= cdb_grant_d;
            cdb_rs_num_q <= cdb_rs_num_d;
            cdb_data_q   <= cdb_data_d;
            cdb_pc_q     <= cdb_pc_d;
            for (int i = 0; i < N_FU; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

    assign bus.fu_busy    = pending_q;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_grant  = cdb_grant_q;
    assign bus.cdb_rs_num = cdb_rs_num_q;
    assign bus.cdb_data   = cdb_data_q;
    assign bus.cdb_pc     = cdb_pc_q;
    assign bus.ovf_err    = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// finish patterns, all compared against a slot/queue style reference model.

module tb_cdb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .PC_W(PW)) bus_if ();

    cdb_arbiter #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .PC_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // stimulus
    logic [N-1:0]  fin;
    logic [DW-1:0] sd [N];
    logic [TW-1:0] st [N];
    logic [PW-1:0] sp [N];

    always_comb begin
        bus_if.fu_finish = fin;
        for (int i = 0; i < N; i++) begin
            bus_if.fu_data[i*DW +: DW] = sd[i];
            bus_if.fu_tag[i*TW +: TW]  = st[i];
            bus_if.fu_pc[i*PW +: PW]   = sp[i];
        end
    end

    // reference model: a slot per FU holding at most one result
    bit            m_full [N];
    logic [DW-1:0] m_d [N];
    logic [TW-1:0] m_t [N];
    logic [PW-1:0] m_p [N];
    int            m_ptr;
    bit            m_ovf;
    bit            e_valid;
    logic [N-1:0]  e_grant;
    logic [DW-1:0] e_data;
    logic [TW-1:0] e_tag;
    logic [PW-1:0] e_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_d[i] = '0; m_t[i] = '0; m_p[i] = '0;
        end
        m_ptr = 0; m_ovf = 1'b0;
        e_valid = 1'b0; e_grant = '0; e_data = '0; e_tag = '0; e_pc = '0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    function automatic void model_step();
        int w;
        int start;
        w = -1;
`ifdef CDB_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (w < 0 && m_full[(start + k) % N]) w = (start + k) % N;
        end
        if (w >= 0) begin
            e_valid = 1'b1;
            e_grant = N'(1) << w;
            e_data = m_d[w]; e_tag = m_t[w]; e_pc = m_p[w];
            m_full[w] = 1'b0;
            m_ptr = (w + 1) % N;
        end else begin
            e_valid = 1'b0; e_grant = '0; e_data = '0; e_tag = '0; e_pc = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (fin[i]) begin
                if (!m_full[i]) begin
                    m_full[i] = 1'b1;
                    m_d[i] = sd[i]; m_t[i] = st[i]; m_p[i] = sp[i];
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic check_all();
        check("fu_busy",    64'(bus_if.fu_busy),    64'(model_busy()));
        check("cdb_valid",  64'(bus_if.cdb_valid),  64'(e_valid));
        check("cdb_grant",  64'(bus_if.cdb_grant),  64'(e_grant));
        check("cdb_rs_num", 64'(bus_if.cdb_rs_num), 64'(e_tag));
        check("cdb_data",   64'(bus_if.cdb_data),   64'(e_data));
        check("cdb_pc",     64'(bus_if.cdb_pc),     64'(e_pc));
        check("ovf_err",    64'(bus_if.ovf_err),    64'(m_ovf));
    endtask

    // Advance one edge; finish pulses last exactly one cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        fin = '0;
        check_all();
    endtask

    task automatic load_fu(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
        fin[i] = 1'b1;
        sd[i] = d; st[i] = t; sp[i] = $urandom;
    endtask

    task automatic load_rand(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) load_fu(i, $urandom, TW'($urandom));
        end
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_busy",  64'(bus_if.fu_busy),   64'(0));
        check("rst_valid", 64'(bus_if.cdb_valid), 64'(0));
        check("rst_ovf",   64'(bus_if.ovf_err),   64'(0));
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        fin = '0;
        for (int i = 0; i < N; i++) begin
            sd[i] = '0; st[i] = '0; sp[i] = '0;
        end
        rst = 1'b0;
        model_reset();
        #12;
        check_all();
        rst = 1'b1;
        cycle();

        // single result through FU 2 (MUL)
        load_fu(2, 32'h1234_5678, 8'h21);
        cycle();
        check("single_busy_set", 64'(bus_if.fu_busy), 64'(5'b00100));
        check("single_no_bcast", 64'(bus_if.cdb_valid), 64'(0));
        cycle();
        check("single_valid", 64'(bus_if.cdb_valid),  64'(1));
        check("single_grant", 64'(bus_if.cdb_grant),  64'(5'b00100));
        check("single_tag",   64'(bus_if.cdb_rs_num), 64'(8'h21));
        check("single_data",  64'(bus_if.cdb_data),   64'(32'h1234_5678));
        check("single_busy_clr", 64'(bus_if.fu_busy), 64'(0));
        cycle();
        check("single_idle", 64'(bus_if.cdb_valid), 64'(0));

        // all five finish together: five broadcasts with no bubble
        load_rand('1);
        cycle();
        for (int k = 0; k < N; k++) begin
            cycle();
            check("contend_valid", 64'(bus_if.cdb_valid), 64'(1));
`ifndef CDB_RR_EN
            check("contend_order", 64'(bus_if.cdb_grant), 64'(N'(1) << k));
`endif
        end
        cycle();
        cycle();

        // tag 0 still broadcasts
        load_fu(4, 32'hCAFE_0000, 8'h00);
        cycle();
        cycle();
        check("tag0_valid", 64'(bus_if.cdb_valid), 64'(1));

        // overflow: MEM finishes again while it loses arbitration
        load_fu(0, 32'hAAAA_0001, 8'h11);
        load_fu(1, 32'hBBBB_0001, 8'h12);
        cycle();
        load_fu(1, 32'hBBBB_0002, 8'h13);
        cycle();
`ifndef CDB_RR_EN
        check("ovf_set",     64'(bus_if.ovf_err),  64'(1));
        check("ovf_alu_win", 64'(bus_if.cdb_grant), 64'(5'b00001));
`endif
        cycle();
`ifndef CDB_RR_EN
        check("ovf_first_kept", 64'(bus_if.cdb_data), 64'(32'hBBBB_0001));
`endif
        cycle();
        cycle();

        // reset in the middle of activity discards everything
        load_rand('1);
        cycle();
        async_reset();
        cycle();
        check("post_rst_no_bcast", 64'(bus_if.cdb_valid), 64'(0));
        cycle();

        // same-edge regrant on DIV
        load_fu(3, 32'hD1D1_0001, 8'h31);
        cycle();
        load_fu(3, 32'hD1D1_0002, 8'h32);
        cycle();
        check("regrant_old",  64'(bus_if.cdb_data), 64'(32'hD1D1_0001));
        check("regrant_busy", 64'(bus_if.fu_busy),  64'(5'b01000));
        cycle();
        check("regrant_new", 64'(bus_if.cdb_data), 64'(32'hD1D1_0002));
        check("regrant_ovf", 64'(bus_if.ovf_err),  64'(0));
        cycle();

        // ALU finishing every cycle while MUL waits
        load_fu(0, $urandom, 8'h41);
        load_fu(2, $urandom, 8'h42);
        cycle();
        for (int k = 0; k < 6; k++) begin
            load_fu(0, $urandom, TW'($urandom));
            cycle();
        end
        for (int k = 0; k < 4; k++) cycle();

        // random traffic with periodic resets
        for (int r = 0; r < 4; r++) begin
            async_reset();
            for (int c = 0; c < 120; c++) begin
                logic [N-1:0] m;
                for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 99) < 30);
                load_rand(m);
                cycle();
            end
            for (int c = 0; c < 8; c++) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
